mod_3: RTL and testbench
========================

Name: mod_3

Overview:
- Two-table cuckoo-hash insertion engine.
- Caller supplies a 32-bit key and its two precomputed bucket indices, one per table.
- The block inserts the key into table 1, relocating displaced keys between the two tables until a free slot is found or the kick limit is hit.
- It sits behind a hashing front end; the tables are readable through a combinational debug/lookup port.

Parameters:
- DEPTH, 20: entries per table; valid indices 0..DEPTH-1.
- KEY_W, 32: key width.
- IDX_W, 5: index width; must satisfy 2^IDX_W >= DEPTH.
- MAX_KICKS, 16: maximum displacement writes after the initial table-1 write.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  insert request, sampled only in IDLE.
- num  in  KEY_W  key to insert.
- index1  in  IDX_W  key's bucket in table 1.
- index2  in  IDX_W  key's bucket in table 2.
- busy  out  1  high while a relocation chain is in progress.
- done  out  1  one-cycle pulse when an insert finishes.
- dup  out  1  valid with done: key was already present.
- err  out  1  valid with done: index1 or index2 >= DEPTH; nothing written.
- fail  out  1  valid with done: kick limit reached, last displaced key dropped.
- rd_sel  in  1  lookup table select: 0 = table 1, 1 = table 2.
- rd_addr  in  IDX_W  lookup index.
- rd_key  out  KEY_W  stored key, combinational.
- rd_filled  out  1  slot-occupied flag, combinational; reads 0 for out-of-range addresses.

Behaviour:
- Storage: per table, DEPTH entries of {filled, key, alt_idx}. alt_idx is the entry's bucket in the other table.
- Reset (async, rst_n=0): all filled flags, keys and alt_idx = 0; busy/done/dup/err/fail = 0; FSM = IDLE. Reset mid-chain aborts the chain; tables are cleared.
- FSM states: IDLE, KICK.
- IDLE, start=1, checks in this priority order:
  - Range check: index1 or index2 >= DEPTH -> next cycle done=1, err=1; no write.
  - Duplicate check: key matches a filled T1[index1] or filled T2[index2] -> next cycle done=1, dup=1; no write.
  - Otherwise write {1, num, index2} into T1[index1].
    - Slot was empty -> done=1 next cycle (latency 1).
    - Slot was filled -> capture old {key, alt} as carry, target table = 2, kick count = 0, go KICK, busy=1.
- KICK, each cycle:
  - Write {1, carry.key, home index} into target[carry.alt]. home index = the carried key's slot in the table it was evicted from.
  - Target slot was empty -> done=1, busy=0, return to IDLE.
  - Otherwise capture the evicted entry as the new carry, toggle target table, count+1.
  - count reaches MAX_KICKS with a pending carry -> done=1, fail=1, carry discarded, IDLE.
- Status flags: dup/err/fail are valid only in the done cycle and 0 otherwise; done is 0 outside the completion cycle.
- start while busy: ignored.
- Inputs are sampled once, at acceptance.
- Lookup port reflects table contents after the most recent clock edge.
- index1 == index2 is legal: the tables are independent.

Test Plan:
- Reset, then insert 70 (i1=0, i2=10) -> done after 1 cycle; T1[0] = {1, 70}; all T2 entries empty.
- Insert 82 (8, 2), then 11 (11, 19) -> T1[8] = 82, T1[11] = 11; no T2 writes.
- Insert 91 (11, 11) -> T1[11] = 91; 11 relocated to T2[19]; done 2 cycles after start; fail = 0.
- Insert 13 (17, 5) -> T1[17] = 13. Final state: T1 filled at {0, 8, 11, 17}; T2 filled only at 19 = 11.
- Re-insert 82 (8, 2) -> dup=1, tables unchanged. Insert with index1=25 -> err=1, tables unchanged.
- Force a cycle with MAX_KICKS=2 (keys sharing buckets) -> fail=1 on done; no more than 2·DEPTH keys stored. Assert rst_n low mid-chain -> all rd_filled = 0, busy = 0 immediately.

Source files
------------

// File: rtl/mod_3_if.sv
// mod_3_if: insert request/response and lookup bundle for the cuckoo-hash
// insertion engine.
//   start/num/index1/index2 : insert request (master -> engine)
//   busy/done/dup/err/fail  : insert status (engine -> master)
//   rd_sel/rd_addr          : lookup select/address (master -> engine)
//   rd_key/rd_filled        : lookup result, combinational (engine -> master)
interface mod_3_if #(
  parameter int KEY_W = 32,
  parameter int IDX_W = 5
);
  logic             start;
  logic [KEY_W-1:0] num;
  logic [IDX_W-1:0] index1;
  logic [IDX_W-1:0] index2;
  logic             busy;
  logic             done;
  logic             dup;
  logic             err;
  logic             fail;
  logic             rd_sel;
  logic [IDX_W-1:0] rd_addr;
  logic [KEY_W-1:0] rd_key;
  logic             rd_filled;

  modport master (
    output start, num, index1, index2, rd_sel, rd_addr,
    input  busy, done, dup, err, fail, rd_key, rd_filled
  );

  modport slave (
    input  start, num, index1, index2, rd_sel, rd_addr,
    output busy, done, dup, err, fail, rd_key, rd_filled
  );
endinterface

// File: rtl/mod_3.sv
// mod_3: two-table cuckoo-hash insertion engine.
//   clk, rst_n : clock, asynchronous active-low reset (clears both tables)
//   bus        : mod_3_if slave -- insert request/status and lookup port
// A new key always lands in table 1 at index1. If that slot was occupied the
// evicted entry is carried and re-inserted into the other table at its
// stored alternate index, bouncing between tables until an empty slot is hit
// or MAX_KICKS displacement writes have been made (last carry dropped).
module mod_3 #(
  parameter int DEPTH     = 20,
  parameter int KEY_W     = 32,
  parameter int IDX_W     = 5,
  parameter int MAX_KICKS = 16
) (
  input  logic clk,
  input  logic rst_n,
  mod_3_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_KICKS + 1);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_KICK = CNT_W'(MAX_KICKS - 1);

  typedef enum logic {IDLE, KICK} state_t;

  // Table storage: [0] = table 1, [1] = table 2.
  logic             fill_q [2][DEPTH];
  logic [KEY_W-1:0] key_q  [2][DEPTH];
  logic [IDX_W-1:0] alt_q  [2][DEPTH];

  state_t           state_q, state_d;
  logic [KEY_W-1:0] ckey_q, ckey_d;   // carried (evicted) key
  logic [IDX_W-1:0] calt_q, calt_d;   // its slot in the target table
  logic [IDX_W-1:0] chome_q, chome_d; // slot it was evicted from
  logic             tgt_q, tgt_d;     // table the carry goes into
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, dup_q, dup_d, err_q, err_d, fail_q, fail_d;

  // Single write port shared by the accept cycle and every kick cycle.
  logic             we;
  logic             wsel;
  logic [IDX_W-1:0] waddr;
  logic [KEY_W-1:0] wkey;
  logic [IDX_W-1:0] walt;

  always_comb begin
    state_d = state_q;
    ckey_d  = ckey_q;
    calt_d  = calt_q;
    chome_d = chome_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dup_d   = 1'b0;
    err_d   = 1'b0;
    fail_d  = 1'b0;
    we      = 1'b0;
    wsel    = 1'b0;
    waddr   = '0;
    wkey    = '0;
    walt    = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ({1'b0, bus.index1} >= DEPTH_L || {1'b0, bus.index2} >= DEPTH_L) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if ((fill_q[0][bus.index1] && key_q[0][bus.index1] == bus.num) ||
                       (fill_q[1][bus.index2] && key_q[1][bus.index2] == bus.num)) begin
            done_d = 1'b1;
            dup_d  = 1'b1;
          end else begin
            we    = 1'b1;
            wsel  = 1'b0;
            waddr = bus.index1;
            wkey  = bus.num;
            walt  = bus.index2;
            if (fill_q[0][bus.index1]) begin
              ckey_d  = key_q[0][bus.index1];
              calt_d  = alt_q[0][bus.index1];
              chome_d = bus.index1;
              tgt_d   = 1'b1;
              cnt_d   = '0;
              state_d = KICK;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      KICK: begin
        we    = 1'b1;
        wsel  = tgt_q;
        waddr = calt_q;
        wkey  = ckey_q;
        walt  = chome_q;
        if (fill_q[tgt_q][calt_q]) begin
          if (cnt_q == LAST_KICK) begin
            // Budget spent with a key still homeless: drop it.
            done_d  = 1'b1;
            fail_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ckey_d  = key_q[tgt_q][calt_q];
            calt_d  = alt_q[tgt_q][calt_q];
            chome_d = calt_q;
            tgt_d   = ~tgt_q;
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ckey_q  <= '0;
      calt_q  <= '0;
      chome_q <= '0;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
      fail_q  <= 1'b0;
      for (int t = 0; t < 2; t++) begin
        for (int i = 0; i < DEPTH; i++) begin
          fill_q[t][i] <= 1'b0;
          key_q[t][i]  <= '0;
          alt_q[t][i]  <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      ckey_q  <= ckey_d;
      calt_q  <= calt_d;
      chome_q <= chome_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      if (we) begin
        fill_q[wsel][waddr] <= 1'b1;
        key_q[wsel][waddr]  <= wkey;
        alt_q[wsel][waddr]  <= walt;
      end
    end
  end

  logic rd_in;
  assign rd_in = ({1'b0, bus.rd_addr} < DEPTH_L);

  assign bus.busy      = (state_q == KICK);
  assign bus.done      = done_q;
  assign bus.dup       = dup_q;
  assign bus.err       = err_q;
  assign bus.fail      = fail_q;
  assign bus.rd_key    = rd_in ? key_q[bus.rd_sel][bus.rd_addr] : '0;
  assign bus.rd_filled = rd_in ? fill_q[bus.rd_sel][bus.rd_addr] : 1'b0;
endmodule

// File: tb/tb_mod_3.sv
module tb_mod_3;
  localparam int DEPTH = 20;
  localparam int KEY_W = 32;
  localparam int IDX_W = 5;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mod_3_if #(.KEY_W(KEY_W), .IDX_W(IDX_W)) bus ();

  mod_3 #(.DEPTH(DEPTH), .KEY_W(KEY_W), .IDX_W(IDX_W), .MAX_KICKS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Result of the last insert.
  int   lat;
  logic r_busy, r_dup, r_err, r_fail;

  task automatic ins(input logic [31:0] k, input logic [4:0] i1, input logic [4:0] i2);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.num    = k;
    bus.index1 = i1;
    bus.index2 = i2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    r_busy = bus.busy;
    lat = 1;
    while (!bus.done && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
    r_dup  = bus.dup;
    r_err  = bus.err;
    r_fail = bus.fail;
  endtask

  task automatic rd(input string tag, input logic sel, input logic [4:0] a,
                    input logic f, input logic [31:0] k);
    bus.rd_sel  = sel;
    bus.rd_addr = a;
    #1;
    chk({tag, "_filled"}, 32'(bus.rd_filled), 32'(f));
    if (f) chk({tag, "_key"}, bus.rd_key, k);
  endtask

  task automatic count_filled(input logic sel, output int n);
    n = 0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_sel  = sel;
      bus.rd_addr = 5'(a);
      #1;
      if (bus.rd_filled) n++;
    end
  endtask

  task automatic chk_res(input string tag, input int elat, input logic ebusy,
                         input logic edup, input logic eerr, input logic efail);
    chk({tag, "_lat"},  32'(lat),    32'(elat));
    chk({tag, "_busy"}, 32'(r_busy), 32'(ebusy));
    chk({tag, "_dup"},  32'(r_dup),  32'(edup));
    chk({tag, "_err"},  32'(r_err),  32'(eerr));
    chk({tag, "_fail"}, 32'(r_fail), 32'(efail));
  endtask

  initial begin
    int n1, n2;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.start = 1'b0; bus.num = '0; bus.index1 = '0; bus.index2 = '0;
    bus.rd_sel = 1'b0; bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    count_filled(1'b0, n1); count_filled(1'b1, n2);
    chk("rst_fill", 32'(n1 + n2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    ins(70, 0, 10);   chk_res("i70", 1, 0, 0, 0, 0);
    rd("t1_0", 0, 0, 1, 70);
    count_filled(1'b1, n2); chk("t2_empty_a", 32'(n2), 32'd0);

    ins(82, 8, 2);    chk_res("i82", 1, 0, 0, 0, 0);
    ins(11, 11, 19);  chk_res("i11", 1, 0, 0, 0, 0);
    rd("t1_8", 0, 8, 1, 82);
    rd("t1_11a", 0, 11, 1, 11);
    count_filled(1'b1, n2); chk("t2_empty_b", 32'(n2), 32'd0);

    // Same bucket in both tables; 11 moves to its table-2 slot 19.
    ins(91, 11, 11);  chk_res("i91", 2, 1, 0, 0, 0);
    rd("t1_11b", 0, 11, 1, 91);
    rd("t2_19", 1, 19, 1, 11);
    rd("t2_11", 1, 11, 0, 0);

    ins(13, 17, 5);   chk_res("i13", 1, 0, 0, 0, 0);
    rd("t1_17", 0, 17, 1, 13);
    count_filled(1'b0, n1); chk("t1_cnt", 32'(n1), 32'd4);
    count_filled(1'b1, n2); chk("t2_cnt", 32'(n2), 32'd1);

    ins(82, 8, 2);    chk_res("dup_t1", 1, 0, 1, 0, 0);
    ins(11, 11, 19);  chk_res("dup_t2", 1, 0, 1, 0, 0);
    ins(5, 25, 0);    chk_res("err_i1", 1, 0, 0, 1, 0);
    ins(5, 0, 20);    chk_res("err_i2", 1, 0, 0, 1, 0);
    ins(6, 19, 19);   chk_res("edge19", 1, 0, 0, 0, 0);
    rd("t1_19", 0, 19, 1, 6);
    rd("oob", 0, 25, 0, 0);
    count_filled(1'b0, n1); count_filled(1'b1, n2);
    chk("cnt_after_err", 32'(n1 + n2), 32'd6);

    // Three keys sharing (3,4): third one cycles until the 16-kick limit.
    ins(100, 3, 4);   chk_res("iA", 1, 0, 0, 0, 0);
    ins(200, 3, 4);   chk_res("iB", 2, 1, 0, 0, 0);
    rd("t1_3a", 0, 3, 1, 200);
    rd("t2_4a", 1, 4, 1, 100);
    ins(300, 3, 4);   chk_res("iC", 17, 1, 0, 0, 1);
    rd("t1_3b", 0, 3, 1, 200);
    rd("t2_4b", 1, 4, 1, 300);
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("fail_clr", 32'(bus.fail), 32'd0);
    count_filled(1'b0, n1); count_filled(1'b1, n2);
    chk("cnt_after_fail", 32'(n1 + n2), 32'd8);

    // Reset in the middle of a chain.
    @(negedge clk);
    bus.start = 1'b1; bus.num = 400; bus.index1 = 3; bus.index2 = 4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    count_filled(1'b0, n1); count_filled(1'b1, n2);
    chk("rst_mid_fill", 32'(n1 + n2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ins(70, 0, 10);   chk_res("post_rst", 1, 0, 0, 0, 0);
    rd("post_t1_0", 0, 0, 1, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
